// File: rtl/me_req_sequencer.sv
// me_req_sequencer
// Initiator side of the integer-ME req/ack handshake. Walks a frame of
// macroblocks in raster order, issues one four-phase req/ack exchange per
// macroblock, captures the returned minimum SAD / vector diff, and hands each
// result downstream on a valid/ready stream. Only one macroblock is ever in
// flight, so backpressure on res_ready directly stalls the next request.
//
// Optional feature: define ME_FRAME_MIN_EN to add frame_min_sad/frame_min_pos,
// which track the smallest SAD seen in the current frame (earliest wins ties).
module me_req_sequencer #(
  parameter int MB_COLS = 4,
  parameter int MB_ROWS = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        me_req,
  input  logic        me_ack,
  output logic [11:0] me_init_pos,
  input  logic [15:0] me_min_sad,
  input  logic [3:0]  me_min_diff,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [11:0] res_pos,
  output logic [15:0] res_sad,
  output logic [3:0]  res_diff
`ifdef ME_FRAME_MIN_EN
  ,
  output logic [15:0] frame_min_sad,
  output logic [11:0] frame_min_pos
`endif
);

  localparam logic [2:0] S_IDLE          = 3'd0;
  localparam logic [2:0] S_ISSUE         = 3'd1;
  localparam logic [2:0] S_WAIT_ACK      = 3'd2;
  localparam logic [2:0] S_WAIT_ACK_FALL = 3'd3;
  localparam logic [2:0] S_OUTPUT        = 3'd4;
  localparam logic [2:0] S_FINISH        = 3'd5;

  // The wait counter only has to reach TIMEOUT-1: the abort fires on the
  // TIMEOUT-th cycle spent in WAIT_ACK.
  localparam int              WCW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [5:0]      LAST_COL  = 6'(MB_COLS - 1);
  localparam logic [5:0]      LAST_ROW  = 6'(MB_ROWS - 1);

  logic [2:0]     state;
  logic [5:0]     col;
  logic [5:0]     row;
  logic [WCW-1:0] wait_cnt;
  logic           aborted;
  logic           last_col;
  logic           last_mb;

  assign last_col = (col == LAST_COL);
  assign last_mb  = last_col && (row == LAST_ROW);

  // done is a pure decode of FINISH, so it is exactly one cycle wide.
  assign done = (state == S_FINISH);

  // Main sequencer: frame walk, handshake phases, result capture and timeout abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      col         <= '0;
      row         <= '0;
      wait_cnt    <= '0;
      aborted     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      me_req      <= 1'b0;
      me_init_pos <= '0;
      res_valid   <= 1'b0;
      res_pos     <= '0;
      res_sad     <= '0;
      res_diff    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            col         <= '0;
            row         <= '0;
            aborted     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A leftover ack from the responder must clear before a new request.
          if (!me_ack) begin
            me_req      <= 1'b1;
            me_init_pos <= {row, col};
            wait_cnt    <= '0;
            state       <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (me_ack) begin
            res_pos  <= me_init_pos;
            res_sad  <= me_min_sad;
            res_diff <= me_min_diff;
            me_req   <= 1'b0;
            state    <= S_WAIT_ACK_FALL;
          end else if (wait_cnt == WAIT_LAST) begin
            me_req      <= 1'b0;
            timeout_err <= 1'b1;
            aborted     <= 1'b1;
            state       <= S_WAIT_ACK_FALL;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WAIT_ACK_FALL: begin
          if (!me_ack) begin
            if (aborted) begin
              state <= S_FINISH;
            end else begin
              res_valid <= 1'b1;
              state     <= S_OUTPUT;
            end
          end
        end
        S_OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (last_mb) begin
              state <= S_FINISH;
            end else begin
              if (last_col) begin
                col <= '0;
                row <= row + 6'd1;
              end else begin
                col <= col + 6'd1;
              end
              state <= S_ISSUE;
            end
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ME_FRAME_MIN_EN
  // Running frame minimum; strict less-than keeps the earliest of equal SADs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_min_sad <= 16'hFFFF;
      frame_min_pos <= '0;
    end else if ((state == S_IDLE) && start) begin
      frame_min_sad <= 16'hFFFF;
      frame_min_pos <= '0;
    end else if ((state == S_WAIT_ACK) && me_ack && (me_min_sad < frame_min_sad)) begin
      frame_min_sad <= me_min_sad;
      frame_min_pos <= me_init_pos;
    end
  end
`endif

endmodule

// File: tb/tb_me_req_sequencer.sv
// tb_me_req_sequencer
// Self-checking bench for me_req_sequencer on a 2x2 frame with TIMEOUT=8.
// A behavioural ME responder answers requests with random (or planned) SADs;
// expected results are rebuilt from the raster-order rule and the values sent.
module tb_me_req_sequencer;

  localparam int COLS = 2;
  localparam int ROWS = 2;
  localparam int NMB  = COLS * ROWS;
  localparam int TOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        me_req;
  logic        me_ack;
  logic [11:0] me_init_pos;
  logic [15:0] me_min_sad;
  logic [3:0]  me_min_diff;
  logic        res_valid;
  logic        res_ready;
  logic [11:0] res_pos;
  logic [15:0] res_sad;
  logic [3:0]  res_diff;
`ifdef ME_FRAME_MIN_EN
  logic [15:0] frame_min_sad;
  logic [11:0] frame_min_pos;
`endif

  me_req_sequencer #(.MB_COLS(COLS), .MB_ROWS(ROWS), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .timeout_err(timeout_err), .me_req(me_req), .me_ack(me_ack),
    .me_init_pos(me_init_pos), .me_min_sad(me_min_sad), .me_min_diff(me_min_diff),
    .res_valid(res_valid), .res_ready(res_ready), .res_pos(res_pos),
    .res_sad(res_sad), .res_diff(res_diff)
`ifdef ME_FRAME_MIN_EN
    , .frame_min_sad(frame_min_sad), .frame_min_pos(frame_min_pos)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Responder control: 0 = normal, 1 = never ack, 2 = ack stuck high
  int resp_mode = 0;
  int ack_lat = 5;
  int fall_lat = 1;
  bit rand_lat = 1'b0;
  int req_age = 0;
  int fall_age = 0;

  // Ready policy: 0 = always, 1 = random, 2 = stall second result 10 cycles
  int ready_mode = 0;
  int stall_cnt = 0;

  logic [15:0] sad_plan[$];
  logic [15:0] sent_sad[$];
  logic [3:0]  sent_diff[$];
  logic [31:0] obs_q[$];

  int done_cnt, req_rises, req_high_cycles, valid_cycles;
  int stale_viol, spacing_viol, pos_viol, hold_viol, overlap_viol;
  int cycle = 0;
  int last_rise = 0;
  logic prev_req, prev_ack, prev_valid, prev_ready;
  logic [11:0] prev_pos;
  logic [31:0] prev_res;

  // Behavioural ME control unit; drives its inputs 1 ns after each rising edge.
  initial begin
    me_ack = 1'b0;
    me_min_sad = '0;
    me_min_diff = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        me_ack = 1'b0;
        req_age = 0;
        fall_age = 0;
      end else if (resp_mode == 2) begin
        me_ack = 1'b1;
      end else if (me_ack) begin
        if (!me_req) begin
          fall_age++;
          if (fall_age >= fall_lat) begin
            me_ack = 1'b0;
            fall_age = 0;
            if (rand_lat) fall_lat = $urandom_range(1, 3);
          end
        end
      end else if (resp_mode == 0 && me_req) begin
        req_age++;
        if (req_age >= ack_lat) begin
          me_min_sad = (sad_plan.size() > 0) ? sad_plan.pop_front() : 16'($urandom);
          me_min_diff = 4'($urandom);
          sent_sad.push_back(me_min_sad);
          sent_diff.push_back(me_min_diff);
          me_ack = 1'b1;
          req_age = 0;
          if (rand_lat) ack_lat = $urandom_range(1, TOUT - 1);
        end
      end else begin
        req_age = 0;
      end
    end
  end

  // Protocol observer on the falling edge: collects results and rule violations.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (me_req && !prev_req) begin
        req_rises++;
        if (prev_ack) stale_viol++;
        if (req_rises > 1 && cycle - last_rise < 4) spacing_viol++;
        last_rise = cycle;
      end
      if ((prev_req || prev_ack) && (me_req || me_ack) && me_init_pos !== prev_pos) pos_viol++;
      if (prev_valid && !prev_ready && (!res_valid || {res_pos, res_sad, res_diff} !== prev_res)) hold_viol++;
      if (me_req) req_high_cycles++;
      if (res_valid) valid_cycles++;
      if (res_valid && me_req) overlap_viol++;
      if (res_valid && res_ready) obs_q.push_back({res_pos, res_sad, res_diff});
      if (done) done_cnt++;
      prev_req = me_req;
      prev_ack = me_ack;
      prev_valid = res_valid;
      prev_ready = res_ready;
      prev_pos = me_init_pos;
      prev_res = {res_pos, res_sad, res_diff};
    end
  end

  // Reference: result i belongs to MB (i / COLS, i % COLS) and carries the i-th SAD sent.
  function automatic logic [31:0] exp_result(input int i);
    logic [5:0] r;
    logic [5:0] c;
    if (i >= sent_sad.size()) return '1;
    r = 6'(i / COLS);
    c = 6'(i % COLS);
    return {r, c, sent_sad[i], sent_diff[i]};
  endfunction

  // Reference frame minimum: smallest SAD sent, earliest index on ties.
  function automatic logic [27:0] exp_frame_min();
    logic [15:0] best;
    int bi;
    best = 16'hFFFF;
    bi = -1;
    for (int i = 0; i < sent_sad.size(); i++)
      if (sent_sad[i] < best) begin
        best = sent_sad[i];
        bi = i;
      end
    if (bi < 0) return {12'h000, 16'hFFFF};
    return {6'(bi / COLS), 6'(bi % COLS), best};
  endfunction

  task automatic clear_obs();
    obs_q.delete();
    sent_sad.delete();
    sent_diff.delete();
    done_cnt = 0;
    req_rises = 0;
    req_high_cycles = 0;
    valid_cycles = 0;
    stale_viol = 0;
    spacing_viol = 0;
    pos_viol = 0;
    hold_viol = 0;
    overlap_viol = 0;
    stall_cnt = 0;
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_frame(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      case (ready_mode)
        1: res_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (res_valid && obs_q.size() == 1 && stall_cnt < 10) begin
            res_ready = 1'b0;
            stall_cnt++;
          end else begin
            res_ready = 1'b1;
          end
        end
        default: res_ready = 1'b1;
      endcase
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, timeout_err, me_req, res_valid} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b want=00000", {busy, done, timeout_err, me_req, res_valid});
    end
    checks++;
    if (me_init_pos !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_init_pos got=%h want=000", me_init_pos);
    end
    checks++;
    if ({res_pos, res_sad, res_diff} !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_res got=%h want=0", {res_pos, res_sad, res_diff});
    end
`ifdef ME_FRAME_MIN_EN
    checks++;
    if ({frame_min_pos, frame_min_sad} !== {12'h000, 16'hFFFF}) begin
      failures++;
      $display("[TB] FAIL reset_frame_min got=%h want=000ffff", {frame_min_pos, frame_min_sad});
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    clear_obs();
    resp_mode = 0;
    rand_lat = 1'b0;
    ack_lat = 5;
    fall_lat = 1;
    ready_mode = 0;
    sad_plan = '{16'd300, 16'd120, 16'd120, 16'd500};
    do_start();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_busy_after_start got=%b want=1", busy);
    end
    run_frame(400);
    checks++;
    if (obs_q.size() !== NMB) begin
      failures++;
      $display("[TB] FAIL basic_count got=%0d want=%0d", obs_q.size(), NMB);
    end
    for (int i = 0; i < obs_q.size() && i < NMB; i++) begin
      checks++;
      if (obs_q[i] !== exp_result(i)) begin
        failures++;
        $display("[TB] FAIL basic_result%0d got=%h want=%h", i, obs_q[i], exp_result(i));
      end
    end
    checks++;
    if (sent_sad.size() != NMB || sent_sad[2] !== 16'd120) begin
      failures++;
      $display("[TB] FAIL basic_plan_used got=%0d want=%0d", sent_sad.size(), NMB);
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_end got done=%0d busy=%b terr=%b want 1,0,0", done_cnt, busy, timeout_err);
    end
    checks++;
    if (stale_viol + spacing_viol + pos_viol + overlap_viol !== 0) begin
      failures++;
      $display("[TB] FAIL basic_protocol got stale=%0d space=%0d pos=%0d ovl=%0d want 0", stale_viol, spacing_viol, pos_viol, overlap_viol);
    end
`ifdef ME_FRAME_MIN_EN
    checks++;
    if ({frame_min_pos, frame_min_sad} !== {12'h001, 16'd120}) begin
      failures++;
      $display("[TB] FAIL basic_frame_min got=%h want=%h", {frame_min_pos, frame_min_sad}, {12'h001, 16'd120});
    end
`endif
  endtask

  task automatic test_backpressure();
    clear_obs();
    resp_mode = 0;
    ack_lat = 3;
    fall_lat = 1;
    ready_mode = 2;
    do_start();
    run_frame(400);
    ready_mode = 0;
    checks++;
    if (stall_cnt !== 10) begin
      failures++;
      $display("[TB] FAIL bp_stall_applied got=%0d want=10", stall_cnt);
    end
    checks++;
    if (hold_viol !== 0 || overlap_viol !== 0) begin
      failures++;
      $display("[TB] FAIL bp_hold got hold=%0d overlap=%0d want 0,0", hold_viol, overlap_viol);
    end
    checks++;
    if (obs_q.size() !== NMB || req_rises !== NMB) begin
      failures++;
      $display("[TB] FAIL bp_count got res=%0d req=%0d want %0d", obs_q.size(), req_rises, NMB);
    end
    for (int i = 0; i < obs_q.size() && i < NMB; i++) begin
      checks++;
      if (obs_q[i] !== exp_result(i)) begin
        failures++;
        $display("[TB] FAIL bp_result%0d got=%h want=%h", i, obs_q[i], exp_result(i));
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      clear_obs();
      resp_mode = 0;
      rand_lat = 1'b1;
      ack_lat = $urandom_range(1, TOUT - 1);
      fall_lat = $urandom_range(1, 3);
      ready_mode = 1;
      do_start();
      run_frame(800);
      ready_mode = 0;
      checks++;
      if (obs_q.size() !== NMB || done_cnt !== 1) begin
        failures++;
        $display("[TB] FAIL rand%0d_count got res=%0d done=%0d want %0d,1", f, obs_q.size(), done_cnt, NMB);
      end
      for (int i = 0; i < obs_q.size() && i < NMB; i++) begin
        checks++;
        if (obs_q[i] !== exp_result(i)) begin
          failures++;
          $display("[TB] FAIL rand%0d_result%0d got=%h want=%h", f, i, obs_q[i], exp_result(i));
        end
      end
      checks++;
      if (stale_viol + spacing_viol + pos_viol + hold_viol + overlap_viol !== 0) begin
        failures++;
        $display("[TB] FAIL rand%0d_protocol got stale=%0d space=%0d pos=%0d hold=%0d ovl=%0d want 0", f, stale_viol, spacing_viol, pos_viol, hold_viol, overlap_viol);
      end
`ifdef ME_FRAME_MIN_EN
      checks++;
      if ({frame_min_pos, frame_min_sad} !== exp_frame_min()) begin
        failures++;
        $display("[TB] FAIL rand%0d_frame_min got=%h want=%h", f, {frame_min_pos, frame_min_sad}, exp_frame_min());
      end
`endif
    end
    rand_lat = 1'b0;
  endtask

  task automatic test_timeout();
    clear_obs();
    resp_mode = 1;
    ready_mode = 0;
    do_start();
    run_frame(200);
    checks++;
    if (req_high_cycles !== TOUT || req_rises !== 1) begin
      failures++;
      $display("[TB] FAIL timeout_req got high=%0d rises=%0d want %0d,1", req_high_cycles, req_rises, TOUT);
    end
    checks++;
    if (timeout_err !== 1'b1 || done_cnt !== 1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_end got terr=%b done=%0d busy=%b want 1,1,0", timeout_err, done_cnt, busy);
    end
    checks++;
    if (valid_cycles !== 0) begin
      failures++;
      $display("[TB] FAIL timeout_no_result got=%0d want=0", valid_cycles);
    end
    clear_obs();
    resp_mode = 0;
    ack_lat = 2;
    do_start();
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_err_clear got=%b want=0", timeout_err);
    end
    run_frame(400);
    checks++;
    if (obs_q.size() !== NMB || timeout_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_recover got res=%0d terr=%b want %0d,0", obs_q.size(), timeout_err, NMB);
    end
  endtask

  task automatic test_stuck_ack();
    clear_obs();
    resp_mode = 2;
    ack_lat = 4;
    fall_lat = 1;
    repeat (2) @(posedge clk);
    do_start();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (req_rises !== 0 || me_req !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stuck_hold got rises=%0d req=%b busy=%b want 0,0,1", req_rises, me_req, busy);
    end
    resp_mode = 0;
    run_frame(400);
    checks++;
    if (obs_q.size() !== NMB || stale_viol !== 0) begin
      failures++;
      $display("[TB] FAIL stuck_frame got res=%0d stale=%0d want %0d,0", obs_q.size(), stale_viol, NMB);
    end
    for (int i = 0; i < obs_q.size() && i < NMB; i++) begin
      checks++;
      if (obs_q[i] !== exp_result(i)) begin
        failures++;
        $display("[TB] FAIL stuck_result%0d got=%h want=%h", i, obs_q[i], exp_result(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_obs();
    resp_mode = 1;
    do_start();
    n = 0;
    while (me_req !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (me_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_req got=%b want=0", me_req);
    end
    checks++;
    if ({busy, done, timeout_err, res_valid, me_init_pos} !== 16'h0) begin
      failures++;
      $display("[TB] FAIL rstmid_outputs got=%h want=0", {busy, done, timeout_err, res_valid, me_init_pos});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_obs();
    resp_mode = 0;
    ack_lat = 3;
    do_start();
    run_frame(400);
    checks++;
    if (obs_q.size() !== NMB || done_cnt !== 1) begin
      failures++;
      $display("[TB] FAIL rstmid_restart got res=%0d done=%0d want %0d,1", obs_q.size(), done_cnt, NMB);
    end
    checks++;
    if (obs_q.size() == 0 || obs_q[0][31:20] !== 12'h000) begin
      failures++;
      $display("[TB] FAIL rstmid_first_pos got=%h want=000", (obs_q.size() == 0) ? 12'hfff : obs_q[0][31:20]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_random_frames();
    test_timeout();
    test_stuck_ack();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
